// File: rtl/seg7_scan_decoder_if.sv
// Bus bundle between the seven-segment display path and its receive-side monitor.
// The master drives the scanned anode/cathode lines and observes the decoded view.
// The slave is the decoder: it samples the lines and presents the decoded view.
interface seg7_scan_decoder_if;
  logic [3:0] an;
  logic [7:0] cat;
  logic [3:0] dig0_code;
  logic [3:0] dig1_code;
  logic [3:0] dig2_code;
  logic [2:0] dig_valid;
  logic [1:0] est_out;
  logic       est_valid;
  logic       glyph_err;

  modport master (
    output an, cat,
    input  dig0_code, dig1_code, dig2_code, dig_valid, est_out, est_valid, glyph_err
  );

  modport slave (
    input  an, cat,
    output dig0_code, dig1_code, dig2_code, dig_valid, est_out, est_valid, glyph_err
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Receive-side monitor for a multiplexed 4-anode / 8-cathode seven-segment bus.
// Stage 1 registers the raw lines, stage 2 decodes the lit glyph into per-digit
// code/valid registers with blanking timeouts, stage 3 reconstructs the 2-bit
// display state from the decoded digit set.
module seg7_scan_decoder #(
  parameter int BLANK_TIMEOUT = 16,
  parameter int CNT_W         = 8
) (
  input logic             clk,
  input logic             rest,
  seg7_scan_decoder_if.slave bus
);

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(BLANK_TIMEOUT);

  logic [3:0]       an_q;
  logic [7:0]       cat_q;
  logic             unused_dp;

  logic [3:0]       code_q [3];
  logic [3:0]       code_d [3];
  logic [CNT_W-1:0] cnt_q  [3];
  logic [CNT_W-1:0] cnt_d  [3];
  logic [2:0]       valid_q;
  logic [2:0]       valid_d;
  logic             glyph_err_q;
  logic             err_d;

  logic             glyph_legal;
  logic             glyph_blank;
  logic [3:0]       glyph_code;
  logic             sel_one;
  logic [1:0]       sel_idx;
  logic             bus_idle;

  logic [1:0]       est_q;
  logic             est_valid_q;
  logic [1:0]       est_d;
  logic             est_match;

  // The decimal point never contributes to the glyph, so it is deliberately dropped.
  assign unused_dp = cat_q[7];

  // Stage 1: capture the raw bus so nothing downstream sees an unregistered input.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      an_q  <= 4'hF;
      cat_q <= 8'hFF;
    end else begin
      an_q  <= bus.an;
      cat_q <= bus.cat;
    end
  end

  // Map the active-low segment pattern back to its hex value, flagging blank and illegal shapes.
  always_comb begin
    glyph_legal = 1'b1;
    glyph_blank = 1'b0;
    glyph_code  = 4'h0;
    case (cat_q[6:0])
      7'h40: glyph_code = 4'h0;
      7'h79: glyph_code = 4'h1;
      7'h24: glyph_code = 4'h2;
      7'h30: glyph_code = 4'h3;
      7'h19: glyph_code = 4'h4;
      7'h12: glyph_code = 4'h5;
      7'h02: glyph_code = 4'h6;
      7'h78: glyph_code = 4'h7;
      7'h00: glyph_code = 4'h8;
      7'h10: glyph_code = 4'h9;
      7'h08: glyph_code = 4'hA;
      7'h03: glyph_code = 4'hB;
      7'h46: glyph_code = 4'hC;
      7'h21: glyph_code = 4'hD;
      7'h06: glyph_code = 4'hE;
      7'h0E: glyph_code = 4'hF;
      7'h7F: begin
        glyph_legal = 1'b0;
        glyph_blank = 1'b1;
      end
      default: glyph_legal = 1'b0;
    endcase
  end

  // Classify the anode sample: idle, exactly one of the three real digits, or a bus fault.
  always_comb begin
    bus_idle = (an_q == 4'hF);
    sel_one  = 1'b0;
    sel_idx  = 2'd0;
    if (an_q[3]) begin
      case (an_q[2:0])
        3'b110: begin sel_one = 1'b1; sel_idx = 2'd0; end
        3'b101: begin sel_one = 1'b1; sel_idx = 2'd1; end
        3'b011: begin sel_one = 1'b1; sel_idx = 2'd2; end
        default: ;
      endcase
    end
  end

  // Per-digit update: a refresh of the selected digit wins; every other digit ages toward blank.
  always_comb begin
    valid_d = valid_q;
    err_d   = !bus_idle && !sel_one;
    for (int k = 0; k < 3; k++) begin
      code_d[k] = code_q[k];
      cnt_d[k]  = cnt_q[k];
      if (sel_one && (sel_idx == 2'(k))) begin
        if (glyph_legal) begin
          code_d[k]  = glyph_code;
          valid_d[k] = 1'b1;
          cnt_d[k]   = '0;
        end else if (glyph_blank) begin
          valid_d[k] = 1'b0;
          cnt_d[k]   = '0;
        end else begin
          valid_d[k] = 1'b0;
          err_d      = 1'b1;
        end
      end else begin
        if (cnt_q[k] != TIMEOUT) begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
        if (cnt_d[k] == TIMEOUT) begin
          valid_d[k] = 1'b0;
        end
      end
    end
  end

  // Stage 2: hold the decoded digit set, its freshness counters and the fault pulse.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      for (int k = 0; k < 3; k++) begin
        code_q[k] <= 4'h0;
        cnt_q[k]  <= TIMEOUT;
      end
      valid_q     <= 3'b000;
      glyph_err_q <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        code_q[k] <= code_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
      valid_q     <= valid_d;
      glyph_err_q <= err_d;
    end
  end

  // Recognise which of the four legal display patterns the digit set currently shows.
  always_comb begin
    est_match = 1'b0;
    est_d     = 2'b00;
    if (valid_q == 3'b001 && code_q[0] == 4'h0) begin
      est_match = 1'b1;
      est_d     = 2'b00;
    end else if (valid_q == 3'b001 && code_q[0] == 4'h1) begin
      est_match = 1'b1;
      est_d     = 2'b01;
    end else if (valid_q == 3'b011 && code_q[0] == 4'h2 && code_q[1] == 4'hA) begin
      est_match = 1'b1;
      est_d     = 2'b10;
    end else if (valid_q == 3'b111 && code_q[0] == 4'h3 && code_q[1] == 4'hA &&
                 code_q[2] == 4'hF) begin
      est_match = 1'b1;
      est_d     = 2'b11;
    end
  end

  // Stage 3: register the reconstructed state, keeping the last good state when none matches.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      est_q       <= 2'b00;
      est_valid_q <= 1'b0;
    end else begin
      est_valid_q <= est_match;
      if (est_match) begin
        est_q <= est_d;
      end
    end
  end

  assign bus.dig0_code = code_q[0];
  assign bus.dig1_code = code_q[1];
  assign bus.dig2_code = code_q[2];
  assign bus.dig_valid = valid_q;
  assign bus.est_out   = est_q;
  assign bus.est_valid = est_valid_q;
  assign bus.glyph_err = glyph_err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: a driver feeds bus samples and a
// behavioural model pushes the expected decoded view into a scoreboard queue;
// an independent monitor pops and compares once per clock.
module tb_seg7_scan_decoder;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rest;
  always #5 clk = ~clk;

  seg7_scan_decoder_if bus();

  seg7_scan_decoder #(.BLANK_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk  (clk),
    .rest (rest),
    .bus  (bus)
  );

  typedef struct packed {
    logic [3:0] c0;
    logic [3:0] c1;
    logic [3:0] c2;
    logic [2:0] v;
    logic [1:0] eo;
    logic       ev;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  logic [6:0] glyphTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: what each digit last showed, whether that was a lit glyph, and its age.
  int         mCode [3];
  bit         mLit  [3];
  int         mAge  [3];
  logic [1:0] mEst;
  bit         mEstV;

  function automatic int decodeGlyph(input logic [6:0] p);
    if (p == 7'h7F) return 16;
    for (int i = 0; i < 16; i++) if (glyphTab[i] == p) return i;
    return -1;
  endfunction

  function automatic logic [2:0] modelValid();
    logic [2:0] v;
    for (int k = 0; k < 3; k++) v[k] = mLit[k] && (mAge[k] < TO);
    return v;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      mCode[k] = 0;
      mLit[k]  = 0;
      mAge[k]  = TO;
    end
    mEst  = 2'b00;
    mEstV = 0;
  endtask

  task automatic modelStep(input logic [3:0] an, input logic [7:0] cat);
    logic [2:0] v;
    int st;
    int lows;
    int sel;
    int g;
    bit err;
    exp_t e;
    v  = modelValid();
    st = -1;
    if (v == 3'b001 && mCode[0] == 0) st = 0;
    else if (v == 3'b001 && mCode[0] == 1) st = 1;
    else if (v == 3'b011 && mCode[0] == 2 && mCode[1] == 10) st = 2;
    else if (v == 3'b111 && mCode[0] == 3 && mCode[1] == 10 && mCode[2] == 15) st = 3;
    mEstV = (st >= 0);
    if (st >= 0) mEst = 2'(st);
    lows = 0;
    sel  = -1;
    err  = 0;
    for (int i = 0; i < 4; i++) if (!an[i]) lows++;
    if (lows == 1 && an[3]) begin
      for (int i = 0; i < 3; i++) if (!an[i]) sel = i;
    end else if (lows != 0) begin
      err = 1;
    end
    for (int k = 0; k < 3; k++) begin
      if (k == sel) begin
        g = decodeGlyph(cat[6:0]);
        if (g >= 0 && g < 16) begin
          mCode[k] = g;
          mLit[k]  = 1;
          mAge[k]  = 0;
        end else if (g == 16) begin
          mLit[k] = 0;
          mAge[k] = 0;
        end else begin
          mLit[k] = 0;
          err     = 1;
        end
      end else if (mAge[k] < TO) begin
        mAge[k]++;
      end
    end
    e.c0  = 4'(mCode[0]);
    e.c1  = 4'(mCode[1]);
    e.c2  = 4'(mCode[2]);
    e.v   = modelValid();
    e.eo  = mEst;
    e.ev  = mEstV;
    e.err = err;
    sb.push_back(e);
  endtask

  task automatic checkField(input string name, input logic [3:0] act, input logic [3:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("dig0_code", bus.dig0_code, e.c0);
    checkField("dig1_code", bus.dig1_code, e.c1);
    checkField("dig2_code", bus.dig2_code, e.c2);
    checkField("dig_valid", {1'b0, bus.dig_valid}, {1'b0, e.v});
    checkField("est_out", {2'b00, bus.est_out}, {2'b00, e.eo});
    checkField("est_valid", {3'b000, bus.est_valid}, {3'b000, e.ev});
    checkField("glyph_err", {3'b000, bus.glyph_err}, {3'b000, e.err});
  endtask

  task automatic checkResetOutputs();
    exp_t z;
    z = '0;
    checkOutput(z);
  endtask

  task automatic applyStimulus(input logic [3:0] an, input logic [7:0] cat);
    @(negedge clk);
    bus.an  = an;
    bus.cat = cat;
    modelStep(an, cat);
  endtask

  task automatic applyReset();
    @(negedge clk);
    rest    = 1'b1;
    bus.an  = 4'hF;
    bus.cat = 8'hFF;
    #1;
    checkResetOutputs();
    sb.delete();
    modelReset();
    repeat (2) @(negedge clk);
    rest = 1'b0;
  endtask

  task automatic showState(input int st);
    case (st)
      0: applyStimulus(4'b1110, 8'hC0);
      1: applyStimulus(4'b1110, 8'hF9);
      2: begin
        applyStimulus(4'b1110, 8'hA4);
        applyStimulus(4'b1101, 8'h88);
      end
      default: begin
        applyStimulus(4'b1110, 8'hB0);
        applyStimulus(4'b1101, 8'h88);
        applyStimulus(4'b1011, 8'h8E);
        applyStimulus(4'b1011, 8'h8E);
      end
    endcase
  endtask

  task automatic randomSample();
    logic [3:0] an;
    logic [7:0] cat;
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) an = 4'hF;
    else if (r <= 6) begin
      case ($urandom_range(0, 2))
        0: an = 4'b1110;
        1: an = 4'b1101;
        default: an = 4'b1011;
      endcase
    end else an = 4'($urandom);
    r = $urandom_range(0, 9);
    if (r < 7) cat = {1'($urandom), glyphTab[$urandom_range(0, 15)]};
    else if (r == 7) cat = {1'($urandom), 7'h7F};
    else cat = 8'($urandom);
    applyStimulus(an, cat);
  endtask

  // Monitor: once the pipeline holds a sample that has passed stage 2, compare it.
  always @(posedge clk) begin
    #1;
    if (!rest && sb.size() >= 2) begin
      checkOutput(sb.pop_front());
    end
  end

  initial begin
    rest    = 1'b1;
    bus.an  = 4'hF;
    bus.cat = 8'hFF;
    modelReset();
    #2;
    checkResetOutputs();
    @(negedge clk);
    rest = 1'b0;

    repeat (6) showState(0);
    repeat (6) showState(2);
    repeat (4) showState(3);
    applyReset();
    repeat (5) showState(1);

    repeat (4) showState(2);
    repeat (25) applyStimulus(4'b1110, 8'hA4);

    applyStimulus(4'b1110, 8'hFF);
    applyStimulus(4'b1110, 8'hC0);
    applyStimulus(4'b1110, 8'h55);
    applyStimulus(4'b1110, 8'h7E);
    repeat (4) applyStimulus(4'b0000, 8'h00);
    applyStimulus(4'b0111, 8'hC0);
    applyStimulus(4'b1100, 8'hC0);
    repeat (3) applyStimulus(4'hF, 8'h00);

    for (int round = 0; round < 80; round++) begin
      if ($urandom_range(0, 1) == 0) begin
        int st;
        int n;
        st = $urandom_range(0, 3);
        n  = $urandom_range(2, 10);
        for (int i = 0; i < n; i++) showState(st);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(10, 22)) applyStimulus(4'hF, 8'hFF);
      end else begin
        repeat ($urandom_range(5, 30)) randomSample();
      end
      if ($urandom_range(0, 19) == 0) applyReset();
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
